// File: rtl/mp_ff_array.sv
// mp_ff_array: flip-flop register array with one masked write port,
// NUM_RD independent registered read ports and a per-entry valid bit
// that can be flash-cleared. Read-during-write is selected per instance
// by WRITE_FIRST.
module mp_ff_array #(
  parameter int S_INDEX     = 4,
  parameter int WIDTH       = 32,
  parameter int NUM_RD      = 2,
  parameter int WMASK_W     = 4,
  parameter int WRITE_FIRST = 1
) (
  input  logic                        clk0,
  input  logic                        rst0_n,
  input  logic                        clr0,
  input  logic                        web0,
  input  logic [S_INDEX-1:0]          waddr0,
  input  logic [WMASK_W-1:0]          wmask0,
  input  logic [WIDTH-1:0]            wdin0,
  input  logic [NUM_RD-1:0]           rcsb,
  input  logic [NUM_RD*S_INDEX-1:0]   raddr,
  output logic [NUM_RD*WIDTH-1:0]     dout,
  output logic [NUM_RD-1:0]           rhit,
  output logic [NUM_RD-1:0]           rresp
);

  localparam int DEPTH  = 1 << S_INDEX;
  localparam int LANE_W = WIDTH / WMASK_W;

  // Reject parameter sets the lane slicing cannot represent.
  generate
    if (WIDTH % WMASK_W != 0) begin : g_bad_mask
      $error("mp_ff_array: WIDTH must be a multiple of WMASK_W");
    end
    if (NUM_RD < 1) begin : g_bad_rd
      $error("mp_ff_array: NUM_RD must be at least 1");
    end
  endgenerate

  // Read handshake: a port issues a request by holding rcsb[p] low across
  // a rising edge; there is no back-pressure. On the following cycle
  // rresp[p] is high for exactly one cycle and dout/rhit for that port
  // carry the response. While rcsb[p] is high, rresp[p] is low and the
  // port's dout/rhit hold the last response unchanged.

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_nxt;
  logic               wr_act;
  logic [WIDTH-1:0]   wr_merged;
  logic [WIDTH-1:0]   rd_data [NUM_RD];
  logic [NUM_RD-1:0]  rd_hit;
  logic [S_INDEX-1:0] rd_addr;

  // Write is only real when at least one lane is enabled; merged word
  // combines new lanes with the unwritten lanes of the current entry.
  always_comb begin
    wr_act    = ~web0 & (|wmask0);
    wr_merged = mem[waddr0];
    for (int k = 0; k < WMASK_W; k++) begin
      if (wmask0[k]) begin
        wr_merged[k*LANE_W +: LANE_W] = wdin0[k*LANE_W +: LANE_W];
      end
    end
  end

  // Post-edge valid vector: clear first, then the write sets its own entry.
  always_comb begin
    valid_nxt = clr0 ? '0 : valid_q;
    if (wr_act) begin
      valid_nxt[waddr0] = 1'b1;
    end
  end

  // Entry storage: commit the merged word on an active write.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_act) begin
      mem[waddr0] <= wr_merged;
    end
  end

  // Valid bits follow the precomputed post-edge vector.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_nxt;
    end
  end

  // Per-port read value, resolving same-edge collisions by policy.
  always_comb begin
    rd_addr = '0;
    rd_hit  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr = raddr[p*S_INDEX +: S_INDEX];
      if ((WRITE_FIRST != 0) && wr_act && (rd_addr == waddr0)) begin
        rd_data[p] = wr_merged;
      end else begin
        rd_data[p] = mem[rd_addr];
      end
      rd_hit[p] = (WRITE_FIRST != 0) ? valid_nxt[rd_addr] : valid_q[rd_addr];
    end
  end

  // Registered read outputs; an idle port keeps its last response.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout  <= '0;
      rhit  <= '0;
      rresp <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rresp[p] <= ~rcsb[p];
        if (!rcsb[p]) begin
          dout[p*WIDTH +: WIDTH] <= rd_data[p];
          rhit[p]                <= rd_hit[p];
        end
      end
    end
  end

endmodule
